handshake_fifo: RTL

HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

---
 rtl/handshake_fifo.sv | 87 ++++++++
 1 files changed

// File: rtl/handshake_fifo.sv
// Valid/ready FIFO with first-word fall-through, registered occupancy count
// and a saturating counter of upstream stall cycles.
module handshake_fifo #(
   parameter int unsigned Depth    = 10,
   parameter int unsigned EntryNum = 4
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic [Depth-1:0]            DataIn,
   input  logic                        DataInVld,
   output logic                        DataInRdy,
   output logic [Depth-1:0]            DataOut,
   output logic                        DataOutVld,
   input  logic                        DataOutRdy,
   output logic [$clog2(EntryNum):0]   Count,
   output logic                        Full,
   output logic                        Empty,
   output logic [15:0]                 StallCnt
);

   localparam int unsigned PtrW = $clog2(EntryNum);
   localparam int unsigned CntW = PtrW + 1;

   logic [Depth-1:0] mem_q [EntryNum];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [15:0]      stall_q, stall_d;
   logic             push, pop;

   always_comb begin
      Full       = (count_q == CntW'(EntryNum));
      Empty      = (count_q == '0);
      // Ready is gated by Rst directly so it drops with no clock edge.
      DataInRdy  = ~Full & ~Rst;
      DataOutVld = ~Empty;
      DataOut    = DataOutVld ? mem_q[rd_ptr_q] : '0;
      Count      = count_q;
      StallCnt   = stall_q;
   end

   assign push = DataInVld & DataInRdy;
   assign pop  = DataOutVld & DataOutRdy;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      stall_d  = stall_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (DataInVld && !DataInRdy && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         stall_q  <= stall_d;
      end
   end

   // Storage is not reset; an empty count masks stale contents.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= DataIn;
      end
   end

endmodule
